hdmi_mode_sequencer: RTL and testbench

Run-time video-mode controller for the HDMI timing generator. It holds the active timing set: H/V totals, sync widths, and active-window start/end. It drives the generator's enable and switches modes only at a frame boundary, followed by a blanking gap, so the sink never sees a torn frame. It sits between the host/config logic (start/stop, mode-request handshake) and the timing generator (enable out, frame-end strobe in).

---
 rtl/hdmi_mode_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_hdmi_mode_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_mode_sequencer.sv
// hdmi_mode_sequencer: run-time video-mode controller for the HDMI timing
// generator. It holds the active timing set and switches modes only at a frame
// boundary, followed by a blanking gap, so the sink never sees a torn frame.
module hdmi_mode_sequencer #(
  parameter int BLANK_CYCLES = 16,
  parameter int TIMEOUT_W    = 22
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        mode_req_i,
  input  logic [1:0]  mode_sel_i,
  output logic        mode_busy_o,
  output logic        mode_ack_o,
  input  logic        frame_end_i,
  input  logic        err_clr_i,
  output logic        err_o,
  output logic        gen_en_o,
  output logic [1:0]  cur_mode_o,
  output logic [11:0] h_total_o,
  output logic [11:0] h_sync_o,
  output logic [11:0] h_start_o,
  output logic [11:0] h_end_o,
  output logic [10:0] v_total_o,
  output logic [10:0] v_sync_o,
  output logic [10:0] v_start_o,
  output logic [10:0] v_end_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_BLANK = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;

  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE = TIMEOUT_W'(1);

  // Packed timing word: {h_total, h_sync, h_start, h_end, v_total, v_sync, v_start, v_end}
  function automatic logic [91:0] mode_timing(input logic [1:0] sel);
    case (sel)
      2'd0:    mode_timing = {12'd800,  12'd96,  12'd144, 12'd784,  11'd525,  11'd2, 11'd35, 11'd515};
      2'd1:    mode_timing = {12'd1650, 12'd40,  12'd260, 12'd1540, 11'd750,  11'd5, 11'd25, 11'd745};
      2'd2:    mode_timing = {12'd2200, 12'd44,  12'd192, 12'd2112, 11'd1125, 11'd5, 11'd41, 11'd1121};
      2'd3:    mode_timing = {12'd1056, 12'd128, 12'd216, 12'd1016, 11'd628,  11'd4, 11'd27, 11'd627};
      default: mode_timing = {12'd800,  12'd96,  12'd144, 12'd784,  11'd525,  11'd2, 11'd35, 11'd515};
    endcase
  endfunction

  logic [2:0]           state_q, state_d;
  logic                 run_q, run_d;
  logic                 pend_q, pend_d;
  logic [1:0]           pend_sel_q, pend_sel_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [BLK_W-1:0]     blk_q, blk_d;
  logic                 err_q, err_d;
  logic                 gen_en_q, gen_en_d;
  logic                 busy_q, busy_d;
  logic                 ack_q, ack_d;
  logic [1:0]           cur_mode_q, cur_mode_d;
  logic [91:0]          timing_q, timing_d;

  logic accept_s;
  logic wd_expire_s;

  // A request is taken only while not busy; the watchdog fires when a drain
  // reaches all-ones without a frame end.
  assign accept_s    = mode_req_i & ~busy_q;
  assign wd_expire_s = (state_q == ST_DRAIN) & ~frame_end_i & (&wd_q);

  // Next-state, counters, request latch and registered-output computation.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_sel_d = pend_sel_q;
    wd_d       = '0;
    blk_d      = '0;
    ack_d      = 1'b0;
    cur_mode_d = cur_mode_q;
    timing_d   = timing_q;

    // stop has priority over start
    if (stop_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d = 1'b1;
    end else begin
      run_d = run_q;
    end

    if (accept_s) begin
      pend_d     = 1'b1;
      pend_sel_d = mode_sel_i;
    end else begin
      pend_d     = pend_q;
      pend_sel_d = pend_sel_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_LOAD;
        end else if (run_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // a stop drain carries no pending load (pend_q is already clear here)
        if (accept_s || !run_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (frame_end_i || wd_expire_s) begin
          state_d = ST_BLANK;
        end else begin
          wd_d = wd_q + WD_ONE;
        end
      end
      ST_BLANK: begin
        if (blk_q == BLK_LAST) begin
          state_d = pend_q ? ST_LOAD : ST_IDLE;
        end else begin
          blk_d = blk_q + BLK_ONE;
        end
      end
      ST_LOAD: begin
        timing_d   = mode_timing(pend_sel_q);
        cur_mode_d = pend_sel_q;
        ack_d      = 1'b1;
        pend_d     = 1'b0;
        state_d    = run_q ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // sticky error: a new expiry wins over a clear in the same cycle
    if (wd_expire_s) begin
      err_d = 1'b1;
    end else if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    gen_en_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    busy_d   = (state_d == ST_DRAIN) || (state_d == ST_BLANK) || (state_d == ST_LOAD);
  end

  // State and output registers with asynchronous reset to mode 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      run_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_sel_q <= 2'd0;
      wd_q       <= '0;
      blk_q      <= '0;
      err_q      <= 1'b0;
      gen_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      cur_mode_q <= 2'd0;
      timing_q   <= mode_timing(2'd0);
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      pend_q     <= pend_d;
      pend_sel_q <= pend_sel_d;
      wd_q       <= wd_d;
      blk_q      <= blk_d;
      err_q      <= err_d;
      gen_en_q   <= gen_en_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      cur_mode_q <= cur_mode_d;
      timing_q   <= timing_d;
    end
  end

  assign mode_busy_o = busy_q;
  assign mode_ack_o  = ack_q;
  assign err_o       = err_q;
  assign gen_en_o    = gen_en_q;
  assign cur_mode_o  = cur_mode_q;
  assign {h_total_o, h_sync_o, h_start_o, h_end_o,
          v_total_o, v_sync_o, v_start_o, v_end_o} = timing_q;

endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// Self-checking bench for hdmi_mode_sequencer: expected modes are queued when a
// request is driven and compared against the timing outputs when the ack comes.
module tb_hdmi_mode_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        stop_i = 1'b0;
  logic        mode_req_i = 1'b0;
  logic [1:0]  mode_sel_i = 2'd0;
  logic        frame_end_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic        mode_busy_o, mode_ack_o, err_o, gen_en_o;
  logic [1:0]  cur_mode_o;
  logic [11:0] h_total_o, h_sync_o, h_start_o, h_end_o;
  logic [10:0] v_total_o, v_sync_o, v_start_o, v_end_o;
  logic [91:0] obs_s;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  logic [1:0] exp_q[$];

  hdmi_mode_sequencer #(.BLANK_CYCLES(16), .TIMEOUT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stop_i(stop_i),
    .mode_req_i(mode_req_i), .mode_sel_i(mode_sel_i), .mode_busy_o(mode_busy_o),
    .mode_ack_o(mode_ack_o), .frame_end_i(frame_end_i), .err_clr_i(err_clr_i),
    .err_o(err_o), .gen_en_o(gen_en_o), .cur_mode_o(cur_mode_o),
    .h_total_o(h_total_o), .h_sync_o(h_sync_o), .h_start_o(h_start_o), .h_end_o(h_end_o),
    .v_total_o(v_total_o), .v_sync_o(v_sync_o), .v_start_o(v_start_o), .v_end_o(v_end_o)
  );

  assign obs_s = {h_total_o, h_sync_o, h_start_o, h_end_o, v_total_o, v_sync_o, v_start_o, v_end_o};

  always #5 clk_i = ~clk_i;

  // count every ack pulse, sampled mid-cycle
  always @(negedge clk_i) if (mode_ack_o) ack_cnt <= ack_cnt + 1;

  function automatic logic [91:0] exp_timing(input logic [1:0] m);
    case (m)
      2'd0:    exp_timing = {12'd800,  12'd96,  12'd144, 12'd784,  11'd525,  11'd2, 11'd35, 11'd515};
      2'd1:    exp_timing = {12'd1650, 12'd40,  12'd260, 12'd1540, 11'd750,  11'd5, 11'd25, 11'd745};
      2'd2:    exp_timing = {12'd2200, 12'd44,  12'd192, 12'd2112, 11'd1125, 11'd5, 11'd41, 11'd1121};
      default: exp_timing = {12'd1056, 12'd128, 12'd216, 12'd1016, 11'd628,  11'd4, 11'd27, 11'd627};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // wait for an ack, pop the scoreboard and compare the loaded mode
  task automatic wait_ack(input int budget, output int cycles);
    logic [1:0] m;
    bit seen;
    seen = 1'b0;
    cycles = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      tick();
      mode_req_i = 1'b0;
      if (mode_ack_o) begin
        seen = 1'b1;
        cycles = i;
      end
    end
    checks++;
    if (!seen) begin
      $display("FAIL ack_timeout: no mode_ack_o within %0d cycles", budget);
      errors++;
    end else if (exp_q.size() == 0) begin
      $display("FAIL ack_unexpected: ack with empty scoreboard");
      errors++;
    end else begin
      m = exp_q.pop_front();
      checks++;
      if (cur_mode_o !== m) begin
        $display("FAIL ack_cur_mode: got %0d expected %0d", cur_mode_o, m);
        errors++;
      end
      checks++;
      if (obs_s !== exp_timing(m)) begin
        $display("FAIL ack_timing: got %h expected %h", obs_s, exp_timing(m));
        errors++;
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if ({gen_en_o, mode_busy_o, mode_ack_o, err_o, cur_mode_o} !== 6'b0 || obs_s !== exp_timing(2'd0)) begin
      $display("FAIL %s: en/busy/ack/err/mode=%b%b%b%b%0d timing=%h expected 0000_0 %h",
               name, gen_en_o, mode_busy_o, mode_ack_o, err_o, cur_mode_o, obs_s, exp_timing(2'd0));
      errors++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_values("reset_values");
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    checks++;
    if (gen_en_o !== 1'b1 || h_total_o !== 12'd800 || v_total_o !== 11'd525 || mode_busy_o !== 1'b0) begin
      $display("FAIL start: en=%b htot=%0d vtot=%0d busy=%b expected 1 800 525 0",
               gen_en_o, h_total_o, v_total_o, mode_busy_o);
      errors++;
    end
  endtask

  task automatic test_stop_drain();
    int a0;
    a0 = ack_cnt;
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    tick();
    checks++;
    if (gen_en_o !== 1'b1 || mode_busy_o !== 1'b1) begin
      $display("FAIL stop_drain_enter: en=%b busy=%b expected 1 1", gen_en_o, mode_busy_o);
      errors++;
    end
    frame_end_i = 1'b1;
    tick();
    frame_end_i = 1'b0;
    checks++;
    if (gen_en_o !== 1'b0) begin
      $display("FAIL stop_frame_end_en: got %b expected 0", gen_en_o);
      errors++;
    end
    repeat (15) tick();
    checks++;
    if (mode_busy_o !== 1'b1) begin
      $display("FAIL stop_blank_len: busy=%b expected 1", mode_busy_o);
      errors++;
    end
    tick();
    checks++;
    if (mode_busy_o !== 1'b0 || gen_en_o !== 1'b0) begin
      $display("FAIL stop_idle: busy=%b en=%b expected 0 0", mode_busy_o, gen_en_o);
      errors++;
    end
    repeat (5) tick();
    checks++;
    if (gen_en_o !== 1'b0 || ack_cnt !== a0 || cur_mode_o !== 2'd0) begin
      $display("FAIL stop_stays_idle: en=%b acks=%0d mode=%0d expected 0 0 0",
               gen_en_o, ack_cnt - a0, cur_mode_o);
      errors++;
    end
  endtask

  task automatic test_idle_request(input logic [1:0] sel);
    int cyc;
    mode_sel_i = sel;
    mode_req_i = 1'b1;
    exp_q.push_back(sel);
    wait_ack(6, cyc);
    checks++;
    if (cyc !== 2 || gen_en_o !== 1'b0) begin
      $display("FAIL idle_req_latency: cycles=%0d en=%b expected 2 0", cyc, gen_en_o);
      errors++;
    end
    tick();
    checks++;
    if (mode_ack_o !== 1'b0 || gen_en_o !== 1'b0) begin
      $display("FAIL idle_ack_pulse: ack=%b en=%b expected 0 0", mode_ack_o, gen_en_o);
      errors++;
    end
  endtask

  task automatic test_run_switch();
    int a0, bad, cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    a0 = ack_cnt;
    mode_sel_i = 2'd1;
    mode_req_i = 1'b1;
    exp_q.push_back(2'd1);
    tick();
    mode_req_i = 1'b0;
    checks++;
    if (mode_busy_o !== 1'b1 || gen_en_o !== 1'b1) begin
      $display("FAIL run_drain_enter: busy=%b en=%b expected 1 1", mode_busy_o, gen_en_o);
      errors++;
    end
    mode_sel_i = 2'd3;
    mode_req_i = 1'b1;
    tick();
    mode_req_i = 1'b0;
    bad = 0;
    for (int i = 0; i < 98; i++) begin
      tick();
      if (gen_en_o !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL run_drain_en: %0d cycles with gen_en_o low, expected 0", bad);
      errors++;
    end
    frame_end_i = 1'b1;
    tick();
    frame_end_i = 1'b0;
    checks++;
    if (gen_en_o !== 1'b0) begin
      $display("FAIL run_frame_end_en: got %b expected 0", gen_en_o);
      errors++;
    end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gen_en_o !== 1'b0 || mode_ack_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL run_blank_load: %0d bad cycles in blank+load, expected 0", bad);
      errors++;
    end
    wait_ack(4, cyc);
    checks++;
    if (cyc !== 1 || gen_en_o !== 1'b1) begin
      $display("FAIL run_ack: cycles=%0d en=%b expected 1 1", cyc, gen_en_o);
      errors++;
    end
    repeat (20) tick();
    checks++;
    if (ack_cnt - a0 !== 1 || cur_mode_o !== 2'd1) begin
      $display("FAIL busy_req_dropped: acks=%0d mode=%0d expected 1 1", ack_cnt - a0, cur_mode_o);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int n, cyc;
    mode_sel_i = 2'd3;
    mode_req_i = 1'b1;
    exp_q.push_back(2'd3);
    tick();
    mode_req_i = 1'b0;
    n = 0;
    for (int i = 1; i <= 400 && n == 0; i++) begin
      tick();
      if (err_o === 1'b1) n = i;
    end
    checks++;
    if (n != 256 || gen_en_o !== 1'b0) begin
      $display("FAIL timeout_err: err after %0d cycles en=%b expected 256 0", n, gen_en_o);
      errors++;
    end
    wait_ack(30, cyc);
    checks++;
    if (cyc !== 17 || err_o !== 1'b1 || gen_en_o !== 1'b1) begin
      $display("FAIL timeout_load: cycles=%0d err=%b en=%b expected 17 1 1", cyc, err_o, gen_en_o);
      errors++;
    end
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    checks++;
    if (err_o !== 1'b0) begin
      $display("FAIL err_clear: got %b expected 0", err_o);
      errors++;
    end
  endtask

  task automatic test_reset_blank();
    int a0;
    a0 = ack_cnt;
    mode_sel_i = 2'd2;
    mode_req_i = 1'b1;
    tick();
    mode_req_i = 1'b0;
    frame_end_i = 1'b1;
    tick();
    frame_end_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (mode_busy_o !== 1'b1 || gen_en_o !== 1'b0) begin
      $display("FAIL blank_before_reset: busy=%b en=%b expected 1 0", mode_busy_o, gen_en_o);
      errors++;
    end
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_values("async_reset");
    tick();
    rst_i = 1'b0;
    repeat (20) tick();
    checks++;
    if (ack_cnt !== a0 || gen_en_o !== 1'b0 || cur_mode_o !== 2'd0) begin
      $display("FAIL reset_lost_req: acks=%0d en=%b mode=%0d expected 0 0 0",
               ack_cnt - a0, gen_en_o, cur_mode_o);
      errors++;
    end
    test_idle_request(2'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_start();
    test_stop_drain();
    test_idle_request(2'd2);
    test_run_switch();
    test_timeout();
    test_reset_blank();
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expected acks never seen, expected 0", exp_q.size());
      errors++;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
